hf_mode_ctrl: RTL and testbench

- Next-generation HF top-level control core that replaces the ad-hoc edge-clocked SPI config logic and fixed 8-way output muxes.
- Samples the ARM SPI command stream synchronously in the ck_1356meg domain and decodes 16-bit commands into the config word and trace enable.
- Routes one of NUM_MODES per-mode output bundles to the pins.
- On any major-mode change, forces a guarded blank interval so the carrier drivers never glitch between modes.

---
 rtl/hf_ctrl_pkg.sv | 36 +++
 rtl/hf_spi_rx.sv | 72 +++++++
 rtl/hf_mode_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hf_mode_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hf_ctrl_pkg.sv
// Shared constants for the HF mode controller: SPI opcodes, major modes,
// bundle bit positions and the FSM state type.
package hf_ctrl_pkg;

    localparam int CMD_W   = 16;
    localparam int OPC_LSB = 12;

    localparam logic [3:0] CMD_SET_CONFREG  = 4'h1;
    localparam logic [3:0] CMD_TRACE_ENABLE = 4'h2;

    localparam logic [2:0] MODE_READER    = 3'd0;
    localparam logic [2:0] MODE_SIMULATOR = 3'd1;
    localparam logic [2:0] MODE_ISO14443A = 3'd2;
    localparam logic [2:0] MODE_SNIFF     = 3'd3;
    localparam logic [2:0] MODE_ISO18092  = 3'd4;
    localparam logic [2:0] MODE_GET_TRACE = 3'd5;
    localparam logic [2:0] MODE_OFF       = 3'd7;

    localparam int BIT_SSP_CLK   = 0;
    localparam int BIT_SSP_DIN   = 1;
    localparam int BIT_SSP_FRAME = 2;
    localparam int BIT_PWR_OE1   = 3;
    localparam int BIT_PWR_OE2   = 4;
    localparam int BIT_PWR_OE3   = 5;
    localparam int BIT_PWR_OE4   = 6;
    localparam int BIT_PWR_LO    = 7;
    localparam int BIT_PWR_HI    = 8;
    localparam int BIT_ADC_CLK   = 9;
    localparam int BIT_DEBUG     = 10;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } hf_state_t;

endpackage

// File: rtl/hf_spi_rx.sv
// SPI command receiver sampled in the ck_1356meg domain: synchronisers,
// MSB-first shifter, saturating bit counter and frame-valid/error strobes.
module hf_spi_rx
    import hf_ctrl_pkg::*;
(
    input  logic             ck_1356meg,
    input  logic             nrst,
    input  logic             spck,
    input  logic             mosi,
    input  logic             ncs,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid,
    output logic             frame_err
);

    localparam logic [4:0] BIT_CNT_FULL = 5'd16;
    localparam logic [4:0] BIT_CNT_MAX  = 5'd17;

    logic [2:0]       spck_sync;
    logic [2:0]       ncs_sync;
    logic [1:0]       mosi_sync;
    logic [CMD_W-1:0] shreg;
    logic [4:0]       bit_cnt;
    logic             spck_rise;
    logic             ncs_rise;
    logic             ncs_active;

    // ncs chain resets high so reset release never looks like a frame end
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            spck_sync <= '0;
            ncs_sync  <= '1;
            mosi_sync <= '0;
        end else begin
            spck_sync <= {spck_sync[1:0], spck};
            ncs_sync  <= {ncs_sync[1:0], ncs};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign spck_rise  = spck_sync[1] & ~spck_sync[2];
    assign ncs_rise   = ncs_sync[1] & ~ncs_sync[2];
    assign ncs_active = ~ncs_sync[1];

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            if (ncs_rise) begin
                bit_cnt <= '0;
                if (bit_cnt == BIT_CNT_FULL) begin
                    cmd       <= shreg;
                    cmd_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end else if (ncs_active && spck_rise) begin
                shreg <= {shreg[CMD_W-2:0], mosi_sync[1]};
                if (bit_cnt != BIT_CNT_MAX) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/hf_mode_ctrl.sv
// HF top-level control: decodes SPI commands into the config word and trace
// enable, and routes the selected mode bundle to the pins with a guarded blank.
//
// state    | meaning
// ST_RUN   | active major mode drives out_bus; same-major updates apply at once
// ST_BLANK | out_bus idle while guard counter runs; pending config lands at terminal count
module hf_mode_ctrl
    import hf_ctrl_pkg::*;
#(
    parameter int               NUM_MODES    = 8,
    parameter int               OUT_W        = 11,
    parameter int               CONF_W       = 9,
    parameter int               MODE_LSB     = 6,
    parameter int               GUARD_CYCLES = 4,
    parameter logic [OUT_W-1:0] IDLE_VALUE   = '0,
    parameter logic [2:0]       OFF_MODE     = MODE_OFF
) (
    input  logic                       ck_1356meg,
    input  logic                       nrst,
    input  logic                       spck,
    input  logic                       mosi,
    input  logic                       ncs,
    input  logic [NUM_MODES*OUT_W-1:0] mode_bus,
    output logic [OUT_W-1:0]           out_bus,
    output logic [CONF_W-1:0]          conf_word,
    output logic [2:0]                 major_mode,
    output logic [3:0]                 minor_mode,
    output logic [1:0]                 subcarrier_frequency,
    output logic                       trace_enable,
    output logic                       blanking,
    output logic                       frame_err,
    output logic [7:0]                 err_cnt
);

    localparam int                  GUARD_W    = $clog2(GUARD_CYCLES + 1);
    localparam logic [GUARD_W-1:0]  GUARD_LOAD = GUARD_W'(GUARD_CYCLES);
    localparam logic [GUARD_W-1:0]  GUARD_TC   = GUARD_W'(1);
    localparam logic [CONF_W-1:0]   CONF_RESET = CONF_W'(OFF_MODE) << MODE_LSB;

    logic [CMD_W-1:0]  cmd;
    logic              cmd_valid;
    logic [3:0]        opcode;
    logic [CONF_W-1:0] cmd_conf;
    logic [2:0]        cmd_major;
    logic              set_conf;
    logic              set_trace;
    logic              unused_cmd_bits;

    hf_state_t         state;
    hf_state_t         state_next;
    logic [GUARD_W-1:0] guard_cnt;
    logic              guard_tc;
    logic [CONF_W-1:0] pending_conf;
    logic              load_now;
    logic              load_pend;
    logic              guard_load;
    logic              out_idle;
    logic [OUT_W-1:0]  bundle_sel;

    hf_spi_rx u_spi_rx (
        .ck_1356meg (ck_1356meg),
        .nrst       (nrst),
        .spck       (spck),
        .mosi       (mosi),
        .ncs        (ncs),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .frame_err  (frame_err)
    );

    assign opcode          = cmd[CMD_W-1:OPC_LSB];
    assign cmd_conf        = cmd[CONF_W-1:0];
    assign cmd_major       = cmd_conf[MODE_LSB+2:MODE_LSB];
    assign set_conf        = cmd_valid && (opcode == CMD_SET_CONFREG);
    assign set_trace       = cmd_valid && (opcode == CMD_TRACE_ENABLE);
    assign unused_cmd_bits = ^cmd[OPC_LSB-1:CONF_W];

    assign major_mode           = conf_word[MODE_LSB+2:MODE_LSB];
    assign minor_mode           = conf_word[3:0];
    assign subcarrier_frequency = conf_word[5:4];
    assign guard_tc             = (guard_cnt == GUARD_TC);

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (set_conf && (cmd_major != major_mode)) begin
                    state_next = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (!set_conf && guard_tc) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Idle on both the entry and exit clocks so neither the old nor a stale bundle leaks out
    always_comb begin
        blanking   = (state == ST_BLANK);
        load_now   = (state == ST_RUN) && set_conf && (cmd_major == major_mode);
        load_pend  = (state == ST_BLANK) && !set_conf && guard_tc;
        guard_load = set_conf && (state_next == ST_BLANK);
        out_idle   = (state == ST_BLANK) || (state_next == ST_BLANK);
    end

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            conf_word    <= CONF_RESET;
            pending_conf <= CONF_RESET;
            guard_cnt    <= '0;
        end else begin
            if (load_now) begin
                conf_word <= cmd_conf;
            end else if (load_pend) begin
                conf_word <= pending_conf;
            end
            if (guard_load) begin
                pending_conf <= cmd_conf;
                guard_cnt    <= GUARD_LOAD;
            end else if ((state == ST_BLANK) && (guard_cnt != '0)) begin
                guard_cnt <= guard_cnt - GUARD_TC;
            end
        end
    end

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            trace_enable <= 1'b0;
            err_cnt      <= '0;
        end else begin
            if (set_trace) begin
                trace_enable <= cmd[0];
            end
            if (frame_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        bundle_sel = IDLE_VALUE;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (int'(major_mode) == k) begin
                bundle_sel = mode_bus[k*OUT_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            out_bus <= IDLE_VALUE;
        end else begin
            out_bus <= out_idle ? IDLE_VALUE : bundle_sel;
        end
    end

endmodule

// File: tb/tb_hf_mode_ctrl.sv
// Self-checking bench for hf_mode_ctrl: table of SPI frames with a queued
// scoreboard, plus hand-written latency, reload, reset and saturation sequences.
module tb_hf_mode_ctrl;

    localparam int NUM_MODES = 8;
    localparam int OUT_W     = 11;
    localparam int CONF_W    = 9;
    localparam int G_LONG    = 80;
    localparam int NVEC      = 9;

    typedef struct {
        logic [8:0] conf;
        logic       trace;
        logic [7:0] err;
        int         blank;
        int         ferr;
        int         chg;
    } exp_t;

    typedef struct {
        int          nbits;
        logic [31:0] data;
        exp_t        exp;
    } vec_t;

    logic ck_1356meg = 1'b0;
    logic nrst = 1'b0;
    logic spck = 1'b0;
    logic mosi = 1'b0;
    logic ncs  = 1'b1;
    logic [NUM_MODES*OUT_W-1:0] mode_bus;

    logic [OUT_W-1:0]  out_bus,    g_out_bus;
    logic [CONF_W-1:0] conf_word,  g_conf_word;
    logic [2:0]        major_mode, g_major_mode;
    logic [3:0]        minor_mode, g_minor_mode;
    logic [1:0]        subcar,     g_subcar;
    logic              trace_enable, g_trace_enable;
    logic              blanking,   g_blanking;
    logic              frame_err,  g_frame_err;
    logic [7:0]        err_cnt,    g_err_cnt;

    int checks = 0;
    int errors = 0;
    int tot_blank = 0, tot_ferr = 0, tot_chg = 0, tot_blank_bad = 0;
    int tot_mode2 = 0, tot_g_mode2 = 0;
    logic [OUT_W-1:0] prev_out = '0;

    exp_t sb_q[$];
    vec_t vecs[NVEC];

    hf_mode_ctrl dut (
        .ck_1356meg           (ck_1356meg),
        .nrst                 (nrst),
        .spck                 (spck),
        .mosi                 (mosi),
        .ncs                  (ncs),
        .mode_bus             (mode_bus),
        .out_bus              (out_bus),
        .conf_word            (conf_word),
        .major_mode           (major_mode),
        .minor_mode           (minor_mode),
        .subcarrier_frequency (subcar),
        .trace_enable         (trace_enable),
        .blanking             (blanking),
        .frame_err            (frame_err),
        .err_cnt              (err_cnt)
    );

    // Long guard instance: lets a second full frame land while still blanking
    hf_mode_ctrl #(.GUARD_CYCLES(G_LONG)) dut_g (
        .ck_1356meg           (ck_1356meg),
        .nrst                 (nrst),
        .spck                 (spck),
        .mosi                 (mosi),
        .ncs                  (ncs),
        .mode_bus             (mode_bus),
        .out_bus              (g_out_bus),
        .conf_word            (g_conf_word),
        .major_mode           (g_major_mode),
        .minor_mode           (g_minor_mode),
        .subcarrier_frequency (g_subcar),
        .trace_enable         (g_trace_enable),
        .blanking             (g_blanking),
        .frame_err            (g_frame_err),
        .err_cnt              (g_err_cnt)
    );

    always #37 ck_1356meg = ~ck_1356meg;

    function automatic logic [OUT_W-1:0] bundle_val(input int k);
        return (k == 7) ? '0 : OUT_W'((k + 1) * 37);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic send_frame(input int nbits, input logic [31:0] data);
        ncs  = 1'b0;
        spck = 1'b0;
        repeat (3) @(negedge ck_1356meg);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = data[i];
            repeat (2) @(negedge ck_1356meg);
            spck = 1'b1;
            repeat (2) @(negedge ck_1356meg);
            spck = 1'b0;
        end
        repeat (2) @(negedge ck_1356meg);
        ncs = 1'b1;
    endtask

    always @(negedge ck_1356meg) begin
        if (blanking) tot_blank++;
        if (blanking && out_bus != '0) tot_blank_bad++;
        if (frame_err) tot_ferr++;
        if (out_bus != prev_out) tot_chg++;
        prev_out = out_bus;
        if (major_mode == 3'd2) tot_mode2++;
        if (g_major_mode == 3'd2 || g_out_bus == bundle_val(2)) tot_g_mode2++;
    end

    initial begin
        #(74 * 60000);
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_blank, s_ferr, s_chg, s_bad, s_m2, s_gm2, n;
        exp_t e;

        vecs[0] = '{16, 32'h1045,  '{9'h045, 1'b0, 8'd0, 4, 0, 1}};
        vecs[1] = '{16, 32'h1043,  '{9'h043, 1'b0, 8'd0, 0, 0, 0}};
        vecs[2] = '{16, 32'h2001,  '{9'h043, 1'b1, 8'd0, 0, 0, 0}};
        vecs[3] = '{16, 32'h2000,  '{9'h043, 1'b0, 8'd0, 0, 0, 0}};
        vecs[4] = '{15, 32'h1045,  '{9'h043, 1'b0, 8'd1, 0, 1, 0}};
        vecs[5] = '{18, 32'h31045, '{9'h043, 1'b0, 8'd2, 0, 1, 0}};
        vecs[6] = '{16, 32'h5123,  '{9'h043, 1'b0, 8'd2, 0, 0, 0}};
        vecs[7] = '{16, 32'h1063,  '{9'h063, 1'b0, 8'd2, 0, 0, 0}};
        vecs[8] = '{16, 32'h11C0,  '{9'h1C0, 1'b0, 8'd2, 4, 0, 1}};

        for (int k = 0; k < NUM_MODES; k++) mode_bus[k*OUT_W +: OUT_W] = bundle_val(k);

        repeat (3) @(negedge ck_1356meg);
        check("rst conf", 32'(conf_word), 32'h1C0);
        check("rst out", 32'(out_bus), 32'h0);
        check("rst blank", 32'(blanking), 32'h0);
        check("rst err", 32'(err_cnt), 32'h0);
        check("rst trace", 32'(trace_enable), 32'h0);
        nrst = 1'b1;
        repeat (5) @(negedge ck_1356meg);
        check("idle major", 32'(major_mode), 32'd7);
        check("idle out", 32'(out_bus), 32'h0);
        check("idle ferr", 32'(frame_err), 32'h0);
        check("idle err", 32'(err_cnt), 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            s_blank = tot_blank; s_ferr = tot_ferr; s_chg = tot_chg; s_bad = tot_blank_bad;
            sb_q.push_back(vecs[i].exp);
            send_frame(vecs[i].nbits, vecs[i].data);
            repeat (20) @(negedge ck_1356meg);
            if (sb_q.size() == 0) begin
                check($sformatf("v%0d queue", i), 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("v%0d conf", i), 32'(conf_word), 32'(e.conf));
                check($sformatf("v%0d major", i), 32'(major_mode), 32'(e.conf[8:6]));
                check($sformatf("v%0d minor", i), 32'(minor_mode), 32'(e.conf[3:0]));
                check($sformatf("v%0d subcar", i), 32'(subcar), 32'(e.conf[5:4]));
                check($sformatf("v%0d trace", i), 32'(trace_enable), 32'(e.trace));
                check($sformatf("v%0d err_cnt", i), 32'(err_cnt), 32'(e.err));
                check($sformatf("v%0d blank cycles", i), 32'(tot_blank - s_blank), 32'(e.blank));
                check($sformatf("v%0d ferr pulses", i), 32'(tot_ferr - s_ferr), 32'(e.ferr));
                check($sformatf("v%0d out changes", i), 32'(tot_chg - s_chg), 32'(e.chg));
                check($sformatf("v%0d out during blank", i), 32'(tot_blank_bad - s_bad), 32'd0);
                check($sformatf("v%0d out", i), 32'(out_bus), 32'(bundle_val(int'(e.conf[8:6]))));
            end
        end

        // Major change from OFF: exact blank window and output latency
        send_frame(16, 32'h1045);
        repeat (3) @(negedge ck_1356meg);
        check("h1 n3 blank", 32'(blanking), 32'd0);
        @(negedge ck_1356meg);
        check("h1 n4 blank", 32'(blanking), 32'd1);
        check("h1 n4 conf held", 32'(conf_word), 32'h1C0);
        check("h1 n4 out", 32'(out_bus), 32'h0);
        repeat (3) @(negedge ck_1356meg);
        check("h1 n7 blank", 32'(blanking), 32'd1);
        @(negedge ck_1356meg);
        check("h1 n8 blank", 32'(blanking), 32'd0);
        check("h1 n8 major", 32'(major_mode), 32'd1);
        check("h1 n8 minor", 32'(minor_mode), 32'd5);
        check("h1 n8 out", 32'(out_bus), 32'h0);
        @(negedge ck_1356meg);
        check("h1 n9 out", 32'(out_bus), 32'(bundle_val(1)));
        repeat (10) @(negedge ck_1356meg);

        // Same-major update: four-clock latency, no blank, no output change
        s_blank = tot_blank; s_chg = tot_chg;
        send_frame(16, 32'h1043);
        repeat (3) @(negedge ck_1356meg);
        check("h2 n3 minor", 32'(minor_mode), 32'd5);
        @(negedge ck_1356meg);
        check("h2 n4 minor", 32'(minor_mode), 32'd3);
        repeat (10) @(negedge ck_1356meg);
        check("h2 blank cycles", 32'(tot_blank - s_blank), 32'd0);
        check("h2 out changes", 32'(tot_chg - s_chg), 32'd0);
        check("h2 out", 32'(out_bus), 32'(bundle_val(1)));

        // Reload during BLANK, back-to-back frames with a one-clock ncs high
        repeat (120) @(negedge ck_1356meg);
        check("h3 g settled", 32'(g_blanking), 32'd0);
        check("h3 g conf start", 32'(g_conf_word), 32'h043);
        s_m2 = tot_mode2; s_gm2 = tot_g_mode2;
        send_frame(16, 32'h1080);
        @(negedge ck_1356meg);
        send_frame(16, 32'h10C0);
        repeat (4) @(negedge ck_1356meg);
        check("h3 g blank at reload", 32'(g_blanking), 32'd1);
        check("h3 g conf held", 32'(g_conf_word), 32'h043);
        n = 0;
        while (g_blanking && n < G_LONG + 40) begin
            n++;
            @(negedge ck_1356meg);
        end
        check("h3 g blank after reload", 32'(n), 32'(G_LONG));
        check("h3 g major", 32'(g_major_mode), 32'd3);
        check("h3 g conf", 32'(g_conf_word), 32'h0C0);
        @(negedge ck_1356meg);
        check("h3 g out", 32'(g_out_bus), 32'(bundle_val(3)));
        check("h3 g saw major2", 32'(tot_g_mode2 - s_gm2), 32'd0);
        check("h3 first frame decoded", 32'(tot_mode2 != s_m2), 32'd1);
        check("h3 major", 32'(major_mode), 32'd3);

        // Reset in the middle of a blank interval
        send_frame(16, 32'h1045);
        repeat (5) @(negedge ck_1356meg);
        check("h4 blank before rst", 32'(blanking), 32'd1);
        nrst = 1'b0;
        #1;
        check("h4 conf", 32'(conf_word), 32'h1C0);
        check("h4 blank", 32'(blanking), 32'd0);
        check("h4 err", 32'(err_cnt), 32'd0);
        check("h4 out", 32'(out_bus), 32'h0);
        check("h4 g blank", 32'(g_blanking), 32'd0);
        @(negedge ck_1356meg);
        nrst = 1'b1;
        repeat (10) @(negedge ck_1356meg);
        check("h4 major after", 32'(major_mode), 32'd7);
        check("h4 blank after", 32'(blanking), 32'd0);

        // Error counter saturation
        s_ferr = tot_ferr;
        for (int i = 0; i < 300; i++) begin
            ncs = 1'b0;
            repeat (3) @(negedge ck_1356meg);
            ncs = 1'b1;
            repeat (3) @(negedge ck_1356meg);
        end
        repeat (5) @(negedge ck_1356meg);
        check("h5 err sat", 32'(err_cnt), 32'd255);
        check("h5 ferr pulses", 32'(tot_ferr - s_ferr), 32'd300);
        check("h5 conf", 32'(conf_word), 32'h1C0);
        check("h5 g err sat", 32'(g_err_cnt), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
